// File: rtl/rc4_key_search_ctrl.sv
// ---------------------------------------------------------------------------
// rc4_key_search_ctrl
//
// Top-level sequencer for the RC4 brute-force key search. For each candidate
// key it resets the three phase engines, then runs them in order:
// S-array init, shuffle (KSA swap), and decrypt/check. It also owns the
// single-port S RAM and grants it to whichever engine is in its phase.
// The key steps until the decrypt engine reports a valid plaintext, the key
// range runs out, or a phase hangs past the watchdog limit.
//
// Handshake with the engines (one rule for all three):
//   The controller raises <eng>_start for exactly one cycle in the GO state.
//   The engine raises <eng>_done as a sticky level when finished. The level
//   is only sampled in the matching WAIT state and is cleared by eng_reset.
//   dec_ok is only looked at on the cycle after dec_done was seen (CHECK).
//   At that point dec_done is still high because it is sticky.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start                  begin a search (IDLE / FOUND / EXHAUSTED / ERROR)
//   init_done/shuf_done/dec_done, dec_ok   engine status
//   init_*/shuf_*/dec_*    per-engine RAM requests (addr, data, wren)
//   s_address/s_data/s_wren  muxed S RAM port
//   eng_reset              reset to all engines
//   init_start/shuf_start/dec_start  one-cycle start pulses
//   secret_key             current candidate key
//   phase                  0=none, 1=init, 2=shuffle, 3=decrypt
//   busy/found/exhausted/error  status flags
//   dbg_state              raw FSM state, for observation only
// ---------------------------------------------------------------------------
module rc4_key_search_ctrl #(
  parameter logic [23:0] KEY_START   = 24'h000000,
  parameter logic [23:0] KEY_END     = 24'h3FFFFF,
  parameter logic [15:0] WDOG_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        init_done,
  input  logic        shuf_done,
  input  logic        dec_done,
  input  logic        dec_ok,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_data,
  input  logic        init_wren,
  input  logic [7:0]  shuf_addr,
  input  logic [7:0]  shuf_data,
  input  logic        shuf_wren,
  input  logic [7:0]  dec_addr,
  input  logic [7:0]  dec_data,
  input  logic        dec_wren,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  output logic        eng_reset,
  output logic        init_start,
  output logic        shuf_start,
  output logic        dec_start,
  output logic [23:0] secret_key,
  output logic [1:0]  phase,
  output logic        busy,
  output logic        found,
  output logic        exhausted,
  output logic        error,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RST_ENG   = 4'd1,
    S_INIT_GO   = 4'd2,
    S_INIT_WAIT = 4'd3,
    S_SHUF_GO   = 4'd4,
    S_SHUF_WAIT = 4'd5,
    S_DEC_GO    = 4'd6,
    S_DEC_WAIT  = 4'd7,
    S_CHECK     = 4'd8,
    S_NEXT_KEY  = 4'd9,
    S_FOUND     = 4'd10,
    S_EXHAUSTED = 4'd11,
    S_ERROR     = 4'd12
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_key;
  logic [23:0] w_key_nxt;
  logic [15:0] r_wdog;
  logic [15:0] w_wdog_nxt;
  logic        w_wdog_last;

  // The watchdog counts the cycles already spent in a WAIT state. On the
  // last allowed cycle without a done, the FSM gives up. The result is
  // exactly WDOG_CYCLES cycles in WAIT before ERROR.
  assign w_wdog_last = (r_wdog == (WDOG_CYCLES - 16'd1));

  // -------------------------------------------------------------------------
  // State, key and watchdog registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_key   <= KEY_START;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_wdog_nxt  = r_wdog;

    case (r_state)
      // Idle and the terminal states all hold the key and wait for start.
      S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: begin
        if (start) begin
          w_state_nxt = S_RST_ENG;
          w_key_nxt   = KEY_START;
        end
      end

      S_RST_ENG: w_state_nxt = S_INIT_GO;

      S_INIT_GO: begin
        w_wdog_nxt  = '0;
        w_state_nxt = S_INIT_WAIT;
      end

      S_INIT_WAIT: begin
        if (init_done) begin
          w_state_nxt = S_SHUF_GO;
        end else if (w_wdog_last) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_wdog_nxt = r_wdog + 16'd1;
        end
      end

      S_SHUF_GO: begin
        w_wdog_nxt  = '0;
        w_state_nxt = S_SHUF_WAIT;
      end

      S_SHUF_WAIT: begin
        if (shuf_done) begin
          w_state_nxt = S_DEC_GO;
        end else if (w_wdog_last) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_wdog_nxt = r_wdog + 16'd1;
        end
      end

      S_DEC_GO: begin
        w_wdog_nxt  = '0;
        w_state_nxt = S_DEC_WAIT;
      end

      S_DEC_WAIT: begin
        if (dec_done) begin
          w_state_nxt = S_CHECK;
        end else if (w_wdog_last) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_wdog_nxt = r_wdog + 16'd1;
        end
      end

      // The range test runs before the increment, so the key never wraps
      // past KEY_END. It also handles KEY_START == KEY_END (one key only).
      S_CHECK: begin
        if (dec_ok) begin
          w_state_nxt = S_FOUND;
        end else if (r_key == KEY_END) begin
          w_state_nxt = S_EXHAUSTED;
        end else begin
          w_state_nxt = S_NEXT_KEY;
        end
      end

      S_NEXT_KEY: begin
        w_key_nxt   = r_key + 24'd1;
        w_state_nxt = S_RST_ENG;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    phase      = 2'd0;
    init_start = 1'b0;
    shuf_start = 1'b0;
    dec_start  = 1'b0;
    busy       = 1'b1;
    found      = 1'b0;
    exhausted  = 1'b0;
    error      = 1'b0;

    case (r_state)
      S_IDLE:      busy = 1'b0;
      S_INIT_GO:   begin phase = 2'd1; init_start = 1'b1; end
      S_INIT_WAIT: phase = 2'd1;
      S_SHUF_GO:   begin phase = 2'd2; shuf_start = 1'b1; end
      S_SHUF_WAIT: phase = 2'd2;
      S_DEC_GO:    begin phase = 2'd3; dec_start = 1'b1; end
      S_DEC_WAIT:  phase = 2'd3;
      S_FOUND:     begin busy = 1'b0; found = 1'b1; end
      S_EXHAUSTED: begin busy = 1'b0; exhausted = 1'b1; end
      S_ERROR:     begin busy = 1'b0; error = 1'b1; end
      default:     busy = 1'b1;
    endcase
  end

  // The engines stay in reset while the controller reset is high. This keeps
  // the dones cleared even before the FSM has passed through RST_ENG.
  assign eng_reset  = reset | (r_state == S_RST_ENG);
  assign secret_key = r_key;
  assign dbg_state  = r_state;

  // -------------------------------------------------------------------------
  // S RAM mux: purely combinational, steered by the phase. A non-granted
  // engine's write enable can never reach the RAM.
  // -------------------------------------------------------------------------
  always_comb begin
    s_address = 8'd0;
    s_data    = 8'd0;
    s_wren    = 1'b0;
    case (phase)
      2'd1: begin
        s_address = init_addr;
        s_data    = init_data;
        s_wren    = init_wren;
      end
      2'd2: begin
        s_address = shuf_addr;
        s_data    = shuf_data;
        s_wren    = shuf_wren;
      end
      2'd3: begin
        s_address = dec_addr;
        s_data    = dec_data;
        s_wren    = dec_wren;
      end
      default: begin
        s_address = 8'd0;
        s_data    = 8'd0;
        s_wren    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rc4_key_search_ctrl
//
// Directed bench for rc4_key_search_ctrl. Two controller instances are used:
//   u_dut_a : KEY_START=000000, KEY_END=3FFFFF, WDOG_CYCLES=16
//   u_dut_b : KEY_START=3FFFFD, KEY_END=3FFFFF, WDOG_CYCLES=16
// Stub engines raise a sticky done five or so cycles after their start pulse.
// The stubs clear on eng_reset. The shuffle stub of instance A can be made
// to hang on one chosen key.
// ---------------------------------------------------------------------------
module tb_rc4_key_search_ctrl;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_SHUF_WAIT = 4'd5;
  localparam logic [3:0] ST_DEC_WAIT  = 4'd7;
  localparam logic [3:0] ST_ERROR     = 4'd12;

  // ---------------------------------------------------------------- instance A
  logic        start_a = 1'b0;
  logic        init_done_a, shuf_done_a, dec_done_a, dec_ok_a;
  logic [7:0]  init_addr_a = '0, init_data_a = '0;
  logic [7:0]  shuf_addr_a = '0, shuf_data_a = '0;
  logic [7:0]  dec_addr_a = '0, dec_data_a = '0;
  logic        init_wren_a = 1'b0, shuf_wren_a = 1'b0, dec_wren_a = 1'b0;
  logic [7:0]  s_address_a, s_data_a;
  logic        s_wren_a, eng_reset_a;
  logic        init_start_a, shuf_start_a, dec_start_a;
  logic [23:0] key_a;
  logic [1:0]  phase_a;
  logic        busy_a, found_a, exhausted_a, error_a;
  logic [3:0]  dbg_state_a;

  rc4_key_search_ctrl #(
    .KEY_START(24'h000000), .KEY_END(24'h3FFFFF), .WDOG_CYCLES(16'd16)
  ) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .init_done(init_done_a), .shuf_done(shuf_done_a), .dec_done(dec_done_a),
    .dec_ok(dec_ok_a),
    .init_addr(init_addr_a), .init_data(init_data_a), .init_wren(init_wren_a),
    .shuf_addr(shuf_addr_a), .shuf_data(shuf_data_a), .shuf_wren(shuf_wren_a),
    .dec_addr(dec_addr_a), .dec_data(dec_data_a), .dec_wren(dec_wren_a),
    .s_address(s_address_a), .s_data(s_data_a), .s_wren(s_wren_a),
    .eng_reset(eng_reset_a),
    .init_start(init_start_a), .shuf_start(shuf_start_a), .dec_start(dec_start_a),
    .secret_key(key_a), .phase(phase_a), .busy(busy_a), .found(found_a),
    .exhausted(exhausted_a), .error(error_a), .dbg_state(dbg_state_a)
  );

  // ---------------------------------------------------------------- instance B
  logic        start_b = 1'b0;
  logic        init_done_b, shuf_done_b, dec_done_b;
  logic        dec_ok_b = 1'b0;
  logic [7:0]  zero8 = '0;
  logic        zero1 = 1'b0;
  logic [7:0]  s_address_b, s_data_b;
  logic        s_wren_b, eng_reset_b;
  logic        init_start_b, shuf_start_b, dec_start_b;
  logic [23:0] key_b;
  logic [1:0]  phase_b;
  logic        busy_b, found_b, exhausted_b, error_b;
  logic [3:0]  dbg_state_b;

  rc4_key_search_ctrl #(
    .KEY_START(24'h3FFFFD), .KEY_END(24'h3FFFFF), .WDOG_CYCLES(16'd16)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .init_done(init_done_b), .shuf_done(shuf_done_b), .dec_done(dec_done_b),
    .dec_ok(dec_ok_b),
    .init_addr(zero8), .init_data(zero8), .init_wren(zero1),
    .shuf_addr(zero8), .shuf_data(zero8), .shuf_wren(zero1),
    .dec_addr(zero8), .dec_data(zero8), .dec_wren(zero1),
    .s_address(s_address_b), .s_data(s_data_b), .s_wren(s_wren_b),
    .eng_reset(eng_reset_b),
    .init_start(init_start_b), .shuf_start(shuf_start_b), .dec_start(dec_start_b),
    .secret_key(key_b), .phase(phase_b), .busy(busy_b), .found(found_b),
    .exhausted(exhausted_b), .error(error_b), .dbg_state(dbg_state_b)
  );

  // ---------------------------------------------------------------- stub engines
  // dec_mode: 0 = plaintext always valid, 1 = valid only for key 000003,
  // 2 = never valid.
  int          dec_mode = 0;
  logic        hang_en = 1'b0;
  logic [23:0] hang_key = '0;
  logic        hang_a;
  logic [2:0]  st_a, run_a, done_a;
  logic [1:0]  cnt_a [3];
  logic [2:0]  st_b, run_b, done_b;
  logic [1:0]  cnt_b [3];

  assign hang_a = hang_en && (key_a == hang_key);
  assign st_a = {dec_start_a, shuf_start_a, init_start_a};
  assign st_b = {dec_start_b, shuf_start_b, init_start_b};

  always @(posedge clk) begin
    for (int e = 0; e < 3; e++) begin
      if (eng_reset_a) begin
        run_a[e] <= 1'b0; done_a[e] <= 1'b0; cnt_a[e] <= 2'd0;
      end else if (st_a[e]) begin
        run_a[e] <= 1'b1; cnt_a[e] <= 2'd0;
      end else if (run_a[e] && !done_a[e] && !(e == 1 && hang_a)) begin
        cnt_a[e] <= cnt_a[e] + 2'd1;
        if (cnt_a[e] == 2'd3) done_a[e] <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    for (int e = 0; e < 3; e++) begin
      if (eng_reset_b) begin
        run_b[e] <= 1'b0; done_b[e] <= 1'b0; cnt_b[e] <= 2'd0;
      end else if (st_b[e]) begin
        run_b[e] <= 1'b1; cnt_b[e] <= 2'd0;
      end else if (run_b[e] && !done_b[e]) begin
        cnt_b[e] <= cnt_b[e] + 2'd1;
        if (cnt_b[e] == 2'd3) done_b[e] <= 1'b1;
      end
    end
  end

  assign init_done_a = done_a[0];
  assign shuf_done_a = done_a[1];
  assign dec_done_a  = done_a[2];
  assign dec_ok_a    = done_a[2] && ((dec_mode == 0) ||
                                     (dec_mode == 1 && key_a == 24'h000003));
  assign init_done_b = done_b[0];
  assign shuf_done_b = done_b[1];
  assign dec_done_b  = done_b[2];

  // ---------------------------------------------------------------- monitors
  // Instance A log entry: {event code, 2'b00, phase}. Codes: 4 = eng reset
  // pulse, 1 = init start, 2 = shuf start, 3 = dec start.
  logic [7:0] log_a[$];
  int         rst_cnt_b = 0;
  logic       wrap_b = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (eng_reset_a)  log_a.push_back({4'h4, 2'b00, phase_a});
      if (init_start_a) log_a.push_back({4'h1, 2'b00, phase_a});
      if (shuf_start_a) log_a.push_back({4'h2, 2'b00, phase_a});
      if (dec_start_a)  log_a.push_back({4'h3, 2'b00, phase_a});
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (eng_reset_b) rst_cnt_b <= rst_cnt_b + 1;
      if (busy_b && key_b == 24'h000000) wrap_b <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_log_a(input string tag);
    check({tag, "_len"}, 32'(log_a.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, 32'(log_a[i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
  endtask

  task automatic wait_term_a(input int budget, output int cyc);
    cyc = 0;
    while (!(found_a || exhausted_a || error_a) && cyc < budget) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic wait_state_a(input logic [3:0] st, input logic [23:0] key,
                              input int budget, output int cyc);
    cyc = 0;
    while (!(dbg_state_a == st && key_a == key) && cyc < budget) begin
      @(negedge clk); cyc++;
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int cyc;

    // Reset state (reset held from time 0)
    @(negedge clk); @(negedge clk);
    check("rst_eng_reset", 32'(eng_reset_a), 32'd1);
    check("rst_state",     32'(dbg_state_a), 32'(ST_IDLE));
    check("rst_key_a",     32'(key_a), 32'h000000);
    check("rst_key_b",     32'(key_b), 32'h3FFFFD);
    check("rst_flags",     32'({busy_a, found_a, exhausted_a, error_a}), 32'd0);
    check("rst_starts",    32'({init_start_a, shuf_start_a, dec_start_a}), 32'd0);
    check("rst_mem",       32'({phase_a, s_wren_a, s_address_a, s_data_a}), 32'd0);
    reset = 1'b0;
    #1;
    check("rel_eng_reset", 32'(eng_reset_a), 32'd0);

    // 1: one key, found at once; pulse order and phase at each pulse
    dec_mode = 0;
    log_a.delete();
    pulse_start_a();
    wait_term_a(500, cyc);
    check("t1_timeout", 32'(cyc < 500), 32'd1);
    check("t1_found", 32'({found_a, busy_a, exhausted_a, error_a}), 32'b1000);
    check("t1_key",   32'(key_a), 32'h000000);
    check("t1_phase", 32'(phase_a), 32'd0);
    exp_q = '{8'h40, 8'h11, 8'h22, 8'h33};
    check_log_a("t1_seq");

    // 2: valid only at key 3 -> four full passes
    dec_mode = 1;
    log_a.delete();
    pulse_start_a();
    wait_term_a(1000, cyc);
    check("t2_timeout", 32'(cyc < 1000), 32'd1);
    check("t2_found", 32'({found_a, busy_a}), 32'b10);
    check("t2_key",   32'(key_a), 32'h000003);
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h40); exp_q.push_back(8'h11);
      exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    end
    check_log_a("t2_seq");

    // 4+5: shuffle hangs on key 2; RAM grant during SHUF_WAIT
    dec_mode = 2;
    hang_key = 24'h000002;
    hang_en  = 1'b1;
    pulse_start_a();
    wait_state_a(ST_SHUF_WAIT, 24'h000002, 1000, cyc);
    check("t4_reach_shuf", 32'(cyc < 1000), 32'd1);
    init_wren_a = 1'b1; init_addr_a = 8'h11; init_data_a = 8'h77;
    dec_wren_a  = 1'b1; dec_addr_a  = 8'h22; dec_data_a  = 8'h88;
    shuf_wren_a = 1'b0; shuf_addr_a = 8'hA5; shuf_data_a = 8'h3C;
    #1;
    check("t5_wren_blocked", 32'(s_wren_a), 32'd0);
    check("t5_addr",  32'(s_address_a), 32'hA5);
    check("t5_data",  32'(s_data_a), 32'h3C);
    check("t5_phase", 32'(phase_a), 32'd2);
    shuf_wren_a = 1'b1;
    #1;
    check("t5_wren_shuf", 32'(s_wren_a), 32'd1);
    shuf_wren_a = 1'b0;
    cyc = 0;
    while (!error_a && cyc < 64) begin
      @(negedge clk); cyc++;
    end
    check("t4_wdog_cycles", 32'(cyc), 32'd16);
    check("t4_error", 32'({error_a, busy_a, found_a, exhausted_a}), 32'b1000);
    check("t4_key",   32'(key_a), 32'h000002);
    check("t4_mem_idle", 32'({phase_a, s_wren_a, s_address_a}), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_hold_state", 32'(dbg_state_a), 32'(ST_ERROR));
    check("t4_hold_key",   32'(key_a), 32'h000002);

    // 6: restart from ERROR, abort by reset in DEC_WAIT of key 1
    hang_en = 1'b0;
    init_wren_a = 1'b0; dec_wren_a = 1'b0;
    pulse_start_a();
    wait_state_a(ST_DEC_WAIT, 24'h000001, 1000, cyc);
    check("t6_reach_dec", 32'(cyc < 1000), 32'd1);
    init_wren_a = 1'b1;
    dec_wren_a = 1'b1; dec_addr_a = 8'h5A; dec_data_a = 8'hC3;
    #1;
    check("t6_dec_grant", 32'({s_wren_a, s_address_a, s_data_a}), 32'h15AC3);
    check("t6_phase", 32'(phase_a), 32'd3);
    // start while busy is ignored
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    #1;
    check("t6_busy_start_state", 32'(dbg_state_a), 32'(ST_DEC_WAIT));
    check("t6_busy_start_key",   32'(key_a), 32'h000001);
    reset = 1'b1;
    #1;
    check("t6_abort_eng_reset", 32'(eng_reset_a), 32'd1);
    check("t6_abort_busy",      32'(busy_a), 32'd0);
    check("t6_abort_wren",      32'(s_wren_a), 32'd0);
    check("t6_abort_state",     32'(dbg_state_a), 32'(ST_IDLE));
    @(negedge clk); @(negedge clk);
    check("t6_reset_held_eng",  32'(eng_reset_a), 32'd1);
    reset = 1'b0;
    init_wren_a = 1'b0; dec_wren_a = 1'b0;
    #1;
    check("t6_idle_state", 32'(dbg_state_a), 32'(ST_IDLE));
    check("t6_idle_key",   32'(key_a), 32'h000000);
    dec_mode = 0;
    log_a.delete();
    pulse_start_a();
    wait_term_a(500, cyc);
    check("t6_restart_found", 32'({found_a, busy_a}), 32'b10);
    check("t6_restart_key",   32'(key_a), 32'h000000);
    exp_q = '{8'h40, 8'h11, 8'h22, 8'h33};
    check_log_a("t6_restart_seq");

    // 3: instance B, three keys up to 3FFFFF, never valid
    pulse_start_b();
    cyc = 0;
    while (!(found_b || exhausted_b || error_b) && cyc < 1000) begin
      @(negedge clk); cyc++;
    end
    check("t3_timeout", 32'(cyc < 1000), 32'd1);
    check("t3_exhausted", 32'({exhausted_b, found_b, error_b, busy_b}), 32'b1000);
    check("t3_key",  32'(key_b), 32'h3FFFFF);
    check("t3_tries", 32'(rst_cnt_b), 32'd3);
    check("t3_no_wrap", 32'(wrap_b), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_hold_key", 32'(key_b), 32'h3FFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule
